// File: rtl/cv32e40p_obi_data_arbiter.sv
// rtl/cv32e40p_obi_data_arbiter.sv - two-to-one OBI data-port arbiter with in-order response routing
// Define OBI_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module cv32e40p_obi_data_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [5:0]  m0_atop_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [5:0]  m1_atop_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  output logic [5:0]  data_atop_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic                       r_lock;
  logic                       r_sel;
  logic                       r_prio;
  logic [CNT_W-1:0]           r_count;
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [MAX_OUTSTANDING-1:0] r_fifo;

  logic w_active;
  logic w_sel;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_empty;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Outputs are forced low while reset is held, not just after the next edge.
  assign w_active = ~rst;
  assign w_empty  = (r_count == '0);

  // A pending (ungranted) request keeps the bus until granted; r_prio stays 0 in fixed mode.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock)
      w_sel = r_sel;
    else if (m0_req_i && m1_req_i)
      w_sel = r_prio;
    else if (m1_req_i)
      w_sel = 1'b1;
  end

  assign w_req  = w_active & (w_sel ? m1_req_i : m0_req_i) & (r_count < MAX_CNT);
  assign w_push = w_req & data_gnt_i;
  assign w_pop  = w_active & data_rvalid_i & ~w_empty;
  assign w_head = r_fifo[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock  <= 1'b0;
      r_sel   <= 1'b0;
      r_prio  <= 1'b0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fifo  <= '0;
    end else begin
      r_lock <= w_req & ~data_gnt_i;
      if (w_req && !data_gnt_i)
        r_sel <= w_sel;
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= f_inc(r_wptr);
      end
      if (w_pop)
        r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
`ifdef OBI_ARB_RR_EN
      if (w_push)
        r_prio <= ~w_sel;
`else
      r_prio <= 1'b0;
`endif
    end
  end

  assign data_req_o   = w_req;
  assign data_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
  assign data_we_o    = w_sel ? m1_we_i    : m0_we_i;
  assign data_be_o    = w_sel ? m1_be_i    : m0_be_i;
  assign data_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;
  assign data_atop_o  = w_sel ? m1_atop_i  : m0_atop_i;

  assign m0_gnt_o = w_push & ~w_sel;
  assign m1_gnt_o = w_push &  w_sel;

  assign m0_rvalid_o = w_pop & ~w_head;
  assign m1_rvalid_o = w_pop &  w_head;
  assign m0_rdata_o  = data_rdata_i;
  assign m1_rdata_o  = data_rdata_i;
  assign m0_err_o    = m0_rvalid_o & data_err_i;
  assign m1_err_o    = m1_rvalid_o & data_err_i;

  assign protocol_err_o = w_active & data_rvalid_i & w_empty;
  assign busy_o         = ~w_empty | w_req;

endmodule

// File: doc/cv32e40p_obi_data_arbiter.md
# cv32e40p_obi_data_arbiter

Two-to-one OBI data-port arbiter that shares the core's single data memory port between the load/store unit (port 0) and a secondary master such as a debug or DMA engine (port 1). It sits between the load/store unit's data_* bus and the memory system. It chooses which requester drives the address phase and holds that choice until the grant. It also records the owner of every granted transaction in an in-order ID FIFO, so each response phase goes back to the correct requester.

## Interface
- MAX_OUTSTANDING, default 2: maximum granted-but-unanswered transactions; ID FIFO depth (power of two, ≥1).
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req_i / m1_req_i  input  1  requester address-phase request.
- m0_gnt_o / m1_gnt_o  output  1  grant to requester.
- m0_addr_i / m1_addr_i  input  32  byte address.
- m0_we_i / m1_we_i  input  1  write enable.
- m0_be_i / m1_be_i  input  4  byte enables.
- m0_wdata_i / m1_wdata_i  input  32  write data.
- m0_atop_i / m1_atop_i  input  6  atomic op.
- m0_rvalid_o / m1_rvalid_o  output  1  response valid to requester.
- m0_rdata_o / m1_rdata_o  output  32  read data (copy of data_rdata_i).
- m0_err_o / m1_err_o  output  1  bus error (copy of data_err_i, qualified by rvalid).
- data_req_o  output  1  memory request.
- data_gnt_i  input  1  memory grant.
- data_addr_o  output  32  muxed address.
- data_we_o  output  1  muxed write enable.
- data_be_o  output  4  muxed byte enables.
- data_wdata_o  output  32  muxed write data.
- data_atop_o  output  6  muxed atomic op.
- data_rvalid_i  input  1  memory response valid.
- data_rdata_i  input  32  memory read data.
- data_err_i  input  1  memory error.
- busy_o  output  1  outstanding count ≠ 0 or data_req_o high.
- protocol_err_o  output  1  one-cycle pulse when data_rvalid_i arrives with the FIFO empty.

## Operation
- Selection state:
  - lock_q: 1 while an issued request is still ungranted.
  - sel_q: the locked port.
  - prio_q: round-robin pointer.
- Effective selection:
  - When lock_q=1: sel_q.
  - Otherwise, when only one port requests: that port.
  - Otherwise, when both request: per arbitration policy (see Configuration).
- data_req_o = (selected port's req) AND (count < MAX_OUTSTANDING). data_req_o does not depend combinationally on data_rvalid_i.
- data_* address-phase outputs mux from the selected port. When there is no request they still mux a port (port 0) but are don't-care.
- Grant fan-out: mX_gnt_o = data_gnt_i AND data_req_o AND (selected == X). The non-selected port's gnt is always 0.
- Lock: when data_req_o=1 and data_gnt_i=0, set lock_q=1 and sel_q=selected. Clear lock_q on the granting cycle. A lower-priority request never preempts a pending one, which keeps OBI address stability.
- On grant: push the selected port ID into the FIFO and increment count.
- On data_rvalid_i with count>0: pop the FIFO head and route the response to mX_rvalid_o for X=head. The other port's rvalid stays 0.
- Simultaneous grant and rvalid: push and pop in the same cycle; count unchanged.
- data_rvalid_i with count=0: no rvalid to either port, protocol_err_o=1, state unchanged.
- Count width: $clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset values:
  - State: count=0, FIFO empty, lock_q=0, sel_q=0, prio_q=0.
  - Outputs: all gnt, rvalid, err and data_req_o outputs 0; protocol_err_o=0.
- Zero-cycle request path: mX_req_i → data_req_o, and data_gnt_i → mX_gnt_o, both in the same cycle.
- Zero-cycle response path: data_rvalid_i → mX_rvalid_o in the same cycle.
- Response ordering is strictly in grant order.
- Full (count == MAX_OUTSTANDING): data_req_o=0 until a pop registers; new grant possible the cycle after the pop.
- Reset mid-operation: FIFO and count are cleared. Responses for pre-reset grants are then reported via protocol_err_o.

## Configuration
- OBI_ARB_RR_EN defined: round-robin.
  - When both ports request while unlocked, grant port prio_q.
  - On any grant, prio_q becomes the non-granted port index.
- OBI_ARB_RR_EN undefined: fixed priority.
  - Port 0 (LSU) wins every unlocked tie.
  - prio_q is unused, held at 0.

## Test plan
- Single port 0 read, addr 0x0000_1000, gnt same cycle, rvalid 2 cycles later with rdata 0xDEAD_BEEF → m0_gnt_o=1 in request cycle; m0_rvalid_o=1 with rdata 0xDEAD_BEEF; m1 outputs stay 0; count returns to 0.
- Both ports request continuously, gnt always 1, OBI_ARB_RR_EN defined → grants alternate 0,1,0,1. With the macro undefined → port 0 granted every cycle and port 1 starved.
- Port 1 requests, gnt withheld 3 cycles while port 0 requests in cycle 1 → data_addr_o stays at port 1's address all 4 cycles; port 1 granted first, port 0 next.
- MAX_OUTSTANDING=2: two grants with no rvalid → data_req_o=0 despite m0_req_i=1. An rvalid then routes to the first requester, and a grant follows the next cycle.
- Interleaved grants in order 0,1,0 with responses rdata 1,2,3 → m0 receives 1 and 3, m1 receives 2. A same-cycle grant and rvalid leaves count unchanged.
- data_rvalid_i=1 with count=0 → protocol_err_o pulses 1 cycle, no mX_rvalid_o. Assert rst mid-transaction → all outputs 0 immediately and count=0.
